// File: rtl/hash_table_pkg.sv
// ----------------------------------------------------------------------------
// hash_table_pkg
// Shared types for the hash_table requester:
//   - ht_op_t        : command op codes (insert / delete / search / invalid)
//   - ht_req_state_t : requester FSM states
//   - ht_rsp_t       : captured response (op, key, value, error, timeout)
// The response struct is sized by HT_KEY_WIDTH / HT_VALUE_WIDTH. These are
// the widest key/value a requester instance can carry.
// ----------------------------------------------------------------------------
package hash_table_pkg;

    localparam int HT_KEY_WIDTH   = 32;
    localparam int HT_VALUE_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_INSERT  = 2'b00,
        OP_DELETE  = 2'b01,
        OP_SEARCH  = 2'b10,
        OP_INVALID = 2'b11
    } ht_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        RESP
    } ht_req_state_t;

    typedef struct packed {
        ht_op_t                    op;
        logic [HT_KEY_WIDTH-1:0]   key;
        logic [HT_VALUE_WIDTH-1:0] value;
        logic                      error;
        logic                      timeout;
    } ht_rsp_t;

endpackage

// File: rtl/hash_table_req_fifo.sv
// ----------------------------------------------------------------------------
// hash_table_req_fifo
// Synchronous first-word-fall-through FIFO for queued hash_table commands.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     : write strobe and data (ignored while full)
//   pop, rdata      : read strobe (ignored while empty); rdata shows the head
//   full, empty     : occupancy flags
// DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module hash_table_req_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hash_table_requester.sv
// ----------------------------------------------------------------------------
// hash_table_requester
// Initiator-side sequencer for the hash_table op_en/op_done protocol. Commands
// arrive on a valid/ready stream, are queued in a FIFO, driven one at a time
// into the hash table, and each result is returned on a valid/ready stream.
//
// Ports:
//   clk, rst                          : clock, async active-high reset
//   req_valid/req_ready               : command handshake (ready = FIFO not full)
//   req_op/req_key/req_value          : command (op 11 is rejected with error)
//   rsp_valid/rsp_ready               : response handshake
//   rsp_op/rsp_key                    : echo of the command
//   rsp_value                         : search result, 0 otherwise
//   rsp_error/rsp_timeout             : table error, invalid op, or watchdog
//   ht_key_in/ht_value_in/ht_op_sel   : operand/op to hash_table
//   ht_op_en                          : operation request to hash_table
//   ht_value_out/ht_op_done/ht_op_error: result from hash_table
//   busy                              : FSM active or commands queued
//
// Optional feature: define HT_REQ_TIMEOUT_EN to enable a watchdog that aborts
// an ISSUE phase after TIMEOUT_CYCLES cycles without ht_op_done.
// KEY_WIDTH / VALUE_WIDTH must not exceed HT_KEY_WIDTH / HT_VALUE_WIDTH.
// ----------------------------------------------------------------------------
module hash_table_requester
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_op,
    output logic [KEY_WIDTH-1:0]   rsp_key,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic [KEY_WIDTH-1:0]   ht_key_in,
    output logic [VALUE_WIDTH-1:0] ht_value_in,
    output logic [1:0]             ht_op_sel,
    output logic                   ht_op_en,
    input  logic [VALUE_WIDTH-1:0] ht_value_out,
    input  logic                   ht_op_done,
    input  logic                   ht_op_error,
    output logic                   busy
);

    localparam int ENTRY_W = 2 + KEY_WIDTH + VALUE_WIDTH;

    ht_req_state_t            state, state_d;
    ht_rsp_t                  rsp_q;
    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENTRY_W-1:0]       fifo_rdata;
    logic [1:0]               head_op_raw;
    ht_op_t                   head_op;
    logic [KEY_WIDTH-1:0]     head_key;
    logic [VALUE_WIDTH-1:0]   head_value;
    logic                     tmo_hit;

    hash_table_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({req_op, req_key, req_value}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_op_raw, head_key, head_value} = fifo_rdata;
    assign head_op   = ht_op_t'(head_op_raw);

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;
    // Every pop happens from IDLE, which enforces one command in flight.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

`ifdef HT_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the edge that completes the TIMEOUT_CYCLES-th ISSUE cycle.
    assign tmo_hit = (state == ISSUE) && !ht_op_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  tmo_cnt <= '0;
        else if (fifo_pop)        tmo_cnt <= '0;
        else if (state == ISSUE)  tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // NOTE: the default is assigned before the case so no path leaves
    // state_d unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!fifo_empty) state_d = (head_op == OP_INVALID) ? RESP : ISSUE;
            ISSUE:   if (ht_op_done || tmo_hit) state_d = RELEASE;
            RELEASE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hash-table drive and response capture. ht_* operands stay put for the
    // whole ISSUE phase because they are only loaded on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ht_op_en    <= 1'b0;
            ht_key_in   <= '0;
            ht_value_in <= '0;
            ht_op_sel   <= 2'b00;
            rsp_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        rsp_q.op      <= head_op;
                        rsp_q.key     <= HT_KEY_WIDTH'(head_key);
                        rsp_q.value   <= '0;
                        rsp_q.error   <= (head_op == OP_INVALID);
                        rsp_q.timeout <= 1'b0;
                        if (head_op != OP_INVALID) begin
                            ht_op_en    <= 1'b1;
                            ht_key_in   <= head_key;
                            ht_value_in <= head_value;
                            ht_op_sel   <= head_op;
                        end
                    end
                end
                ISSUE: begin
                    if (ht_op_done) begin
                        ht_op_en    <= 1'b0;
                        rsp_q.error <= ht_op_error;
                        if (rsp_q.op == OP_SEARCH && !ht_op_error)
                            rsp_q.value <= HT_VALUE_WIDTH'(ht_value_out);
                    end else if (tmo_hit) begin
                        ht_op_en      <= 1'b0;
                        rsp_q.error   <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (state == RESP);
    assign rsp_op      = rsp_q.op;
    assign rsp_key     = KEY_WIDTH'(rsp_q.key);
    assign rsp_value   = VALUE_WIDTH'(rsp_q.value);
    assign rsp_error   = rsp_q.error;
    // Without the watchdog the timeout bit is only ever loaded with 0.
    assign rsp_timeout = rsp_q.timeout;
    assign busy        = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_hash_table_requester.sv
// ----------------------------------------------------------------------------
// tb_hash_table_requester
// Directed bench for hash_table_requester with a behavioural hash-table
// responder (programmable latency, error and silent modes).
// ----------------------------------------------------------------------------
module tb_hash_table_requester;

    localparam int KW = 32;
    localparam int VW = 32;
`ifdef HT_REQ_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_op;
    logic [KW-1:0] rsp_key;
    logic [VW-1:0] rsp_value;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [KW-1:0] ht_key_in;
    logic [VW-1:0] ht_value_in;
    logic [1:0]    ht_op_sel;
    logic          ht_op_en;
    logic [VW-1:0] cfg_value = '0;
    logic          ht_op_done = 1'b0;
    logic          ht_op_error = 1'b0;
    logic          busy;

    int total = 0;
    int bad   = 0;

    hash_table_requester #(
        .KEY_WIDTH      (KW),
        .VALUE_WIDTH    (VW),
        .CMD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_key      (req_key),
        .req_value    (req_value),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_op       (rsp_op),
        .rsp_key      (rsp_key),
        .rsp_value    (rsp_value),
        .rsp_error    (rsp_error),
        .rsp_timeout  (rsp_timeout),
        .ht_key_in    (ht_key_in),
        .ht_value_in  (ht_value_in),
        .ht_op_sel    (ht_op_sel),
        .ht_op_en     (ht_op_en),
        .ht_value_out (cfg_value),
        .ht_op_done   (ht_op_done),
        .ht_op_error  (ht_op_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Responder: 0 = normal, 1 = op_error, 2 = silent. Raises op_done on the
    // resp_lat-th falling edge that sees op_en high.
    int resp_mode = 0;
    int resp_lat  = 3;
    int resp_cnt  = 0;
    always @(negedge clk) begin
        if (ht_op_en) begin
            resp_cnt = resp_cnt + 1;
            if (resp_mode != 2 && resp_cnt == resp_lat) begin
                ht_op_done  = 1'b1;
                ht_op_error = (resp_mode == 1);
            end else begin
                ht_op_done  = 1'b0;
                ht_op_error = 1'b0;
            end
        end else begin
            resp_cnt    = 0;
            ht_op_done  = 1'b0;
            ht_op_error = 1'b0;
        end
    end

    // op_en monitor: high-run length, rise count, operand stability.
    int            en_run = 0;
    int            en_last = 0;
    int            en_rises = 0;
    logic          unstable = 1'b0;
    logic [KW-1:0] k0;
    logic [VW-1:0] v0;
    logic [1:0]    s0;
    always @(negedge clk) begin
        if (ht_op_en) begin
            if (en_run == 0) begin
                en_rises = en_rises + 1;
                k0 = ht_key_in;
                v0 = ht_value_in;
                s0 = ht_op_sel;
            end else if ({ht_key_in, ht_value_in, ht_op_sel} != {k0, v0, s0}) begin
                unstable = 1'b1;
            end
            en_run = en_run + 1;
        end else if (en_run != 0) begin
            en_last = en_run;
            en_run  = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [1:0] op, input logic [31:0] key,
                           input logic [31:0] val, input logic err, input logic tmo,
                           output int waited);
        waited = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        while (!rsp_valid && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        check({tag, "_valid"},   rsp_valid, 1);
        check({tag, "_op"},      rsp_op, op);
        check({tag, "_key"},     rsp_key, key);
        check({tag, "_value"},   rsp_value, val);
        check({tag, "_error"},   rsp_error, err);
        check({tag, "_timeout"}, rsp_timeout, tmo);
        check({tag, "_en_low"},  ht_op_en, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    logic [1:0]  b_op  [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [31:0] b_val [6];

    initial begin
        int w;
        int acc;
        int n;
        int rises0;
        int hi;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready",  req_ready, 1);
        check("rst_rsp_valid",  rsp_valid, 0);
        check("rst_ht_op_en",   ht_op_en, 0);
        check("rst_busy",       busy, 0);
        check("rst_rsp_error",  rsp_error, 0);
        check("rst_rsp_value",  rsp_value, 0);
        check("rst_ht_op_sel",  ht_op_sel, 0);
        rst = 1'b0;

        // Insert(1,2), 3-cycle responder
        cfg_value = 32'h0;
        send(2'b00, 32'd1, 32'd2);
        get_rsp("ins", 2'b00, 32'd1, 32'd0, 1'b0, 1'b0, w);
        check("ins_latency",  w, 5);
        check("ins_en_len",   en_last, 3);
        check("ins_en_rises", en_rises, 1);
        check("ins_key_in",   k0, 1);
        check("ins_val_in",   v0, 2);
        check("ins_sel",      s0, 0);
        check("ins_stable",   unstable, 0);
        check("ins_busy",     busy, 0);

        // Search(1) returning 2
        cfg_value = 32'd2;
        send(2'b10, 32'd1, 32'd0);
        get_rsp("srch", 2'b10, 32'd1, 32'd2, 1'b0, 1'b0, w);
        check("srch_sel", s0, 2);

        // Delete(5) with op_error; search with error must report value 0
        resp_mode = 1;
        cfg_value = 32'h99;
        send(2'b01, 32'd5, 32'd0);
        get_rsp("del_err", 2'b01, 32'd5, 32'd0, 1'b1, 1'b0, w);
        send(2'b10, 32'd9, 32'd0);
        get_rsp("srch_err", 2'b10, 32'd9, 32'd0, 1'b1, 1'b0, w);
        resp_mode = 0;

        // Six back-to-back commands with responses stalled
        cfg_value = 32'h55;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            b_val[i] = 32'd100 + 32'(i);
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = b_op[i];
            req_key   = 32'd10 + 32'(i);
            req_value = b_val[i];
            if (req_ready) acc++;
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bb_accepted",  acc, 5);
        check("bb_not_ready", req_ready, 0);
        check("bb_busy",      busy, 1);
        for (int i = 0; i < 5; i++)
            get_rsp("bb", b_op[i], 32'd10 + 32'(i), (b_op[i] == 2'b10) ? 32'h55 : 32'h0,
                    1'b0, 1'b0, w);
        @(negedge clk);
        check("bb_ready_again", req_ready, 1);
        send(b_op[5], 32'd15, b_val[5]);
        get_rsp("bb5", b_op[5], 32'd15, 32'h55, 1'b0, 1'b0, w);
        check("bb_stable", unstable, 0);

        // Invalid op: error response, no hash-table request
        rises0 = en_rises;
        send(2'b11, 32'd7, 32'd0);
        get_rsp("inv", 2'b11, 32'd7, 32'd0, 1'b1, 1'b0, w);
        check("inv_latency",  w, 1);
        check("inv_no_en",    en_rises, rises0);

        // Reset pulse mid-ISSUE
        resp_mode = 2;
        send(2'b00, 32'd20, 32'd200);
        n = 0;
        while (!ht_op_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_en_high", ht_op_en, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en",    ht_op_en, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_rsp",  rsp_valid, 0);
        check("mid_busy",    busy, 0);
        check("mid_en_low",  ht_op_en, 0);

        // Silent responder: watchdog abort or indefinite wait
        cfg_value = 32'h77;
        send(2'b10, 32'd30, 32'd0);
`ifdef HT_REQ_TIMEOUT_EN
        get_rsp("tmo", 2'b10, 32'd30, 32'd0, 1'b1, 1'b1, w);
        check("tmo_en_len", en_last, 8);
`else
        n = 0;
        while (!ht_op_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (ht_op_en) hi++;
            @(negedge clk);
        end
        check("hold_en_100",  hi, 100);
        check("hold_no_rsp",  rsp_valid, 0);
        check("hold_busy",    busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("hold_rst_en",  ht_op_en, 0);
        check("hold_rst_busy", busy, 0);
`endif
        resp_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
